// File: rtl/l2_wb_pkg.sv
// Shared widths, state encodings and entry layout for the L2 write-back buffer.
package l2_wb_pkg;

  localparam int L2WB_ADDR_W = 28;
  localparam int L2WB_DATA_W = 128;

  typedef enum logic [1:0] {U_IDLE, U_WAIT, U_RESP} u_state_t;
  typedef enum logic [1:0] {D_IDLE, D_READ, D_WRITE} d_state_t;

  typedef struct packed {
    logic                   valid;
    logic [L2WB_ADDR_W-1:0] addr;
    logic [L2WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo_cam.sv
// Circular entry store for the write buffer, with an age-ordered address CAM
// and an in-place data write port used for coalescing.
module wb_fifo_cam
  import l2_wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = L2WB_ADDR_W,
  parameter int DATA_W = L2WB_DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              cw_en,
  input  logic [PTR_W-1:0]  cw_idx,
  input  logic [DATA_W-1:0] cw_data,
  input  logic [ADDR_W-1:0] lookup_addr,
  input  logic              excl_head,
  output logic              rd_hit,
  output logic [DATA_W-1:0] rd_data,
  output logic              wr_match,
  output logic [PTR_W-1:0]  wr_idx,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  count,
  output logic              full
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0]  valid_reg;
  logic [ADDR_W-1:0] addr_reg [DEPTH];
  logic [DATA_W-1:0] data_reg [DEPTH];
  logic [PTR_W-1:0]  head_reg;
  logic [PTR_W-1:0]  tail_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [PTR_W-1:0]  rd_idx;
  logic [DEPTH-1:0]  match;

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_reg <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) begin
        valid_reg[tail_reg] <= 1'b1;
        tail_reg            <= tail_reg + PTR_W'(1);
      end
      if (pop) begin
        valid_reg[head_reg] <= 1'b0;
        head_reg            <= head_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Payload storage carries no reset; the valid bits alone define occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_reg[tail_reg] <= push_addr;
      data_reg[tail_reg] <= push_data;
    end
    if (cw_en) begin
      data_reg[cw_idx] <= cw_data;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cam
    assign match[gi] = valid_reg[gi] && (addr_reg[gi] == lookup_addr);
  end

  // Scan oldest to youngest so the last hit seen is the youngest one.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx      = '0;
    rd_hit   = 1'b0;
    rd_idx   = '0;
    wr_match = 1'b0;
    wr_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_reg + PTR_W'(k);
      if (match[idx]) begin
        rd_hit = 1'b1;
        rd_idx = idx;
        if (!(k == 0 && excl_head)) begin
          wr_match = 1'b1;
          wr_idx   = idx;
        end
      end
    end
  end

  assign rd_data   = data_reg[rd_idx];
  assign head_addr = addr_reg[head_reg];
  assign head_data = data_reg[head_reg];
  assign count     = count_reg;
  assign full      = (count_reg == FULL_CNT);

endmodule

// File: rtl/l2_write_buffer.sv
// Write-back buffer between the L2 memory port and main memory: absorbs
// evictions, drains them in the background and forwards buffered data to reads.
module l2_write_buffer
  import l2_wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = L2WB_ADDR_W,
  parameter int DATA_W = L2WB_DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              l2_mem_read,
  input  logic              l2_mem_write,
  input  logic [ADDR_W-1:0] l2_mem_addr,
  input  logic [DATA_W-1:0] l2_mem_wdata,
  output logic [DATA_W-1:0] l2_mem_rdata,
  output logic              l2_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  wb_count,
  output logic              wb_empty
);

  u_state_t          u_state_reg;
  d_state_t          d_state_reg;
  logic              rd_pending_reg;
  logic [ADDR_W-1:0] rd_addr_reg;

  logic              u_idle;
  logic              rd_req;
  logic              wr_req;
  logic              read_miss;
  logic              coalesce;
  logic              push;
  logic              pop;
  logic              excl_head;
  logic              rd_hit;
  logic [DATA_W-1:0] rd_data;
  logic              wr_match;
  logic [PTR_W-1:0]  wr_idx;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              full;

  assign u_idle    = (u_state_reg == U_IDLE) && !l2_mem_ready;
  assign rd_req    = u_idle && l2_mem_read;
  assign wr_req    = u_idle && l2_mem_write && !l2_mem_read;
  assign read_miss = rd_req && !rd_hit;
  assign coalesce  = wr_req && wr_match;
  assign push      = wr_req && !wr_match && !full;
  assign pop       = (d_state_reg == D_WRITE) && mem_ready;

  // The head counts as draining already in the cycle its drain issues, so a
  // coalesce can never land in data that is about to be popped.
  assign excl_head = (d_state_reg == D_WRITE) ||
                     ((d_state_reg == D_IDLE) && !rd_pending_reg && (wb_count != '0));

  wb_fifo_cam #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_addr   (l2_mem_addr),
    .push_data   (l2_mem_wdata),
    .pop         (pop),
    .cw_en       (coalesce),
    .cw_idx      (wr_idx),
    .cw_data     (l2_mem_wdata),
    .lookup_addr (l2_mem_addr),
    .excl_head   (excl_head),
    .rd_hit      (rd_hit),
    .rd_data     (rd_data),
    .wr_match    (wr_match),
    .wr_idx      (wr_idx),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .count       (wb_count),
    .full        (full)
  );

  assign wb_empty = (wb_count == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      u_state_reg  <= U_IDLE;
      l2_mem_ready <= 1'b0;
      l2_mem_rdata <= '0;
    end else begin
      case (u_state_reg)
        U_IDLE: begin
          if (rd_req) begin
            if (rd_hit) begin
              l2_mem_rdata <= rd_data;
              l2_mem_ready <= 1'b1;
              u_state_reg  <= U_RESP;
            end else begin
              u_state_reg <= U_WAIT;
            end
          end else if (coalesce || push) begin
            l2_mem_ready <= 1'b1;
            u_state_reg  <= U_RESP;
          end
        end
        U_WAIT: begin
          if ((d_state_reg == D_READ) && mem_ready) begin
            l2_mem_rdata <= mem_rdata;
            l2_mem_ready <= 1'b1;
            u_state_reg  <= U_RESP;
          end
        end
        U_RESP: begin
          l2_mem_ready <= 1'b0;
          u_state_reg  <= U_IDLE;
        end
        default: begin
          l2_mem_ready <= 1'b0;
          u_state_reg  <= U_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      d_state_reg    <= D_IDLE;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      rd_pending_reg <= 1'b0;
      rd_addr_reg    <= '0;
    end else begin
      // Park a miss that cannot issue this cycle; cleared below if it can.
      if (read_miss) begin
        rd_pending_reg <= 1'b1;
        rd_addr_reg    <= l2_mem_addr;
      end
      case (d_state_reg)
        D_IDLE: begin
          if (rd_pending_reg || read_miss) begin
            mem_read       <= 1'b1;
            mem_addr       <= rd_pending_reg ? rd_addr_reg : l2_mem_addr;
            rd_pending_reg <= 1'b0;
            d_state_reg    <= D_READ;
          end else if (wb_count != '0) begin
            mem_write   <= 1'b1;
            mem_addr    <= head_addr;
            mem_wdata   <= head_data;
            d_state_reg <= D_WRITE;
          end
        end
        D_READ: begin
          if (mem_ready) begin
            mem_read    <= 1'b0;
            d_state_reg <= D_IDLE;
          end
        end
        D_WRITE: begin
          if (mem_ready) begin
            mem_write   <= 1'b0;
            d_state_reg <= D_IDLE;
          end
        end
        default: begin
          mem_read    <= 1'b0;
          mem_write   <= 1'b0;
          d_state_reg <= D_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_write_buffer.sv
// Bench for l2_write_buffer: vector table, directed multi-cycle corners and a
// randomized run checked against a last-written-value memory model.
`timescale 1ns/1ps
module tb_l2_write_buffer;
  import l2_wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 28;
  localparam int DW    = 128;
  localparam int CW    = 3;

  localparam logic [DW-1:0] DA  = {32{4'hA}};
  localparam logic [DW-1:0] DB  = {32{4'hB}};
  localparam logic [DW-1:0] DC  = {32{4'hC}};
  localparam logic [DW-1:0] DD  = {32{4'hD}};
  localparam logic [DW-1:0] DE  = {32{4'hE}};
  localparam logic [DW-1:0] DF  = {32{4'hF}};
  localparam logic [DW-1:0] A5  = {16{8'hA5}};
  localparam logic [DW-1:0] RD1 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  localparam logic [DW-1:0] RD2 = {4{32'h600D_F00D}};

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          l2_mem_read, l2_mem_write;
  logic [AW-1:0] l2_mem_addr;
  logic [DW-1:0] l2_mem_wdata, l2_mem_rdata;
  logic          l2_mem_ready;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ready;
  logic [CW-1:0] wb_count;
  logic          wb_empty;

  always #5 clk = ~clk;

  l2_write_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .l2_mem_read(l2_mem_read), .l2_mem_write(l2_mem_write),
    .l2_mem_addr(l2_mem_addr), .l2_mem_wdata(l2_mem_wdata),
    .l2_mem_rdata(l2_mem_rdata), .l2_mem_ready(l2_mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .wb_count(wb_count), .wb_empty(wb_empty)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] mem_init(input logic [AW-1:0] a);
    return {4{4'h5, a}};
  endfunction

  // Main memory behind the buffer plus the log of completed writes.
  logic [DW-1:0] mem_store [logic [AW-1:0]];
  wb_entry_t     wr_log[$];
  bit            mem_auto = 1'b0;

  function automatic logic [DW-1:0] mem_get(input logic [AW-1:0] a);
    return mem_store.exists(a) ? mem_store[a] : mem_init(a);
  endfunction

  // Reference model: a read always sees the last value written to its address.
  logic [DW-1:0] last_val [logic [AW-1:0]];

  function automatic logic [DW-1:0] model_get(input logic [AW-1:0] a);
    return last_val.exists(a) ? last_val[a] : mem_init(a);
  endfunction

  always @(negedge clk) begin
    if (mem_ready && mem_write)
      wr_log.push_back('{valid: 1'b1, addr: mem_addr, data: mem_wdata});
  end

  // Randomized-latency memory, active only in the random phase.
  initial begin
    int lat;
    lat = 0;
    forever begin
      tick();
      if (mem_auto) begin
        if (mem_ready) begin
          mem_ready = 1'b0;
        end else if (mem_read || mem_write) begin
          if (lat == 0) begin
            mem_ready = 1'b1;
            if (mem_read) mem_rdata = mem_get(mem_addr);
            else          mem_store[mem_addr] = mem_wdata;
            lat = $urandom_range(0, 3);
          end else begin
            lat--;
          end
        end
      end
    end
  end

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
    logic [CW-1:0] exp_count;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic wr, input logic [AW-1:0] a,
                              input logic [DW-1:0] wd, input logic [DW-1:0] rdd,
                              input logic [CW-1:0] cnt);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd; v.exp_rdata = rdd; v.exp_count = cnt;
    return v;
  endfunction

  task automatic clear_req();
    l2_mem_read  = 1'b0;
    l2_mem_write = 1'b0;
  endtask

  task automatic do_reset();
    mem_auto = 1'b0;
    reset = 1'b0;
    clear_req();
    l2_mem_addr = '0; l2_mem_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    tick(); tick();
    reset = 1'b1;
    wr_log.delete();
  endtask

  task automatic evict(input logic [AW-1:0] a, input logic [DW-1:0] d);
    l2_mem_write = 1'b1; l2_mem_addr = a; l2_mem_wdata = d;
    tick();
  endtask

  vec_t          vt[10];
  logic [AW-1:0] exp_a[4];
  logic [DW-1:0] exp_d[4];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_req();
    l2_mem_addr = '0; l2_mem_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    tick(); tick();
    check("rst l2_mem_ready", l2_mem_ready, 0);
    check("rst l2_mem_rdata", l2_mem_rdata, 0);
    check("rst mem_read", mem_read, 0);
    check("rst mem_write", mem_write, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst wb_count", wb_count, 0);
    check("rst wb_empty", wb_empty, 1);
    reset = 1'b1;
    wr_log.delete();

    // Vector table; memory is stalled so the 0x40 head stays draining throughout.
    vt[0] = mk(0, 1, 28'h40, DA, '0, 3'd1);
    vt[1] = mk(1, 0, 28'h40, '0, DA, 3'd1);
    vt[2] = mk(0, 1, 28'h40, DB, '0, 3'd2);
    vt[3] = mk(1, 0, 28'h40, '0, DB, 3'd2);
    vt[4] = mk(0, 1, 28'h41, DC, '0, 3'd3);
    vt[5] = mk(0, 1, 28'h41, DD, '0, 3'd3);
    vt[6] = mk(1, 0, 28'h41, '0, DD, 3'd3);
    vt[7] = mk(0, 1, 28'h42, DE, '0, 3'd4);
    vt[8] = mk(1, 1, 28'h42, DF, DE, 3'd4);
    vt[9] = mk(1, 0, 28'h40, '0, DB, 3'd4);
    for (int i = 0; i < 10; i++) begin
      l2_mem_read = vt[i].rd; l2_mem_write = vt[i].wr;
      l2_mem_addr = vt[i].addr; l2_mem_wdata = vt[i].wdata;
      tick();
      check($sformatf("vec%0d ready", i), l2_mem_ready, 1);
      if (vt[i].rd) check($sformatf("vec%0d rdata", i), l2_mem_rdata, vt[i].exp_rdata);
      check($sformatf("vec%0d count", i), wb_count, vt[i].exp_count);
      check($sformatf("vec%0d no mem_read", i), mem_read, 0);
      $display("vec %0d rd=%0b wr=%0b addr=%0h count=%0d", i, vt[i].rd, vt[i].wr, vt[i].addr, wb_count);
      clear_req();
      tick();
    end
    check("vec drain mem_write", mem_write, 1);
    check("vec drain mem_addr", mem_addr, 28'h40);
    check("vec drain mem_wdata", mem_wdata, DA);
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1; tick();
      mem_ready = 1'b0; tick();
    end
    exp_a[0] = 28'h40; exp_d[0] = DA;
    exp_a[1] = 28'h40; exp_d[1] = DB;
    exp_a[2] = 28'h41; exp_d[2] = DD;
    exp_a[3] = 28'h42; exp_d[3] = DE;
    check("wrlog size", wr_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < wr_log.size()) begin
        check($sformatf("wrlog%0d addr", i), wr_log[i].addr, exp_a[i]);
        check($sformatf("wrlog%0d data", i), wr_log[i].data, exp_d[i]);
      end
    end
    check("vec final empty", wb_empty, 1);
    $display("seq table drained writes=%0d", wr_log.size());

    // Single eviction, then reset while it drains.
    do_reset();
    evict(28'h0000123, A5);
    check("ev1 ready", l2_mem_ready, 1);
    check("ev1 count", wb_count, 1);
    check("ev1 no early write", mem_write, 0);
    clear_req();
    tick();
    check("ev1 mem_write", mem_write, 1);
    check("ev1 mem_addr", mem_addr, 28'h0000123);
    check("ev1 mem_wdata", mem_wdata, A5);
    tick();
    check("ev1 write held", mem_write, 1);
    reset = 1'b0;
    tick();
    check("midrst mem_write", mem_write, 0);
    check("midrst mem_addr", mem_addr, 0);
    check("midrst mem_wdata", mem_wdata, 0);
    check("midrst l2_mem_ready", l2_mem_ready, 0);
    check("midrst wb_count", wb_count, 0);
    check("midrst wb_empty", wb_empty, 1);
    reset = 1'b1;
    tick(); tick(); tick();
    check("postrst mem_write", mem_write, 0);
    check("postrst mem_read", mem_read, 0);
    $display("seq eviction+reset done");

    // Full buffer: fifth eviction stalls until the head pops.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      evict(28'h10 + AW'(i), {32{4'(i)}});
      check($sformatf("fill%0d ready", i), l2_mem_ready, 1);
      clear_req();
      tick();
    end
    check("full count", wb_count, 4);
    evict(28'h14, DF);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall%0d ready", i), l2_mem_ready, 0);
      tick();
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("pop ready low", l2_mem_ready, 0);
    check("pop count", wb_count, 3);
    tick();
    check("fifth ready", l2_mem_ready, 1);
    check("fifth count", wb_count, 4);
    clear_req();
    tick();
    $display("seq full-stall done count=%0d", wb_count);

    // Read miss behind an in-flight drain, then a miss with memory idle.
    do_reset();
    evict(28'h50, DC);
    clear_req();
    tick();
    check("rm drain active", mem_write, 1);
    l2_mem_read = 1'b1; l2_mem_addr = 28'h99;
    tick();
    check("rm wait mem_read0", mem_read, 0);
    tick();
    check("rm wait mem_read1", mem_read, 0);
    check("rm wait ready", l2_mem_ready, 0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("rm after drain mem_write", mem_write, 0);
    check("rm after drain mem_read", mem_read, 0);
    tick();
    check("rm issue mem_read", mem_read, 1);
    check("rm issue mem_addr", mem_addr, 28'h99);
    tick();
    check("rm pending ready", l2_mem_ready, 0);
    mem_rdata = RD1; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("rm ready", l2_mem_ready, 1);
    check("rm rdata", l2_mem_rdata, RD1);
    check("rm mem_read dropped", mem_read, 0);
    clear_req();
    tick();
    l2_mem_read = 1'b1; l2_mem_addr = 28'h77;
    tick();
    check("idle miss mem_read", mem_read, 1);
    check("idle miss mem_addr", mem_addr, 28'h77);
    mem_rdata = RD2; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("idle miss ready", l2_mem_ready, 1);
    check("idle miss rdata", l2_mem_rdata, RD2);
    clear_req();
    tick();
    $display("seq read-miss done");

    // Randomized traffic against the model.
    do_reset();
    mem_store.delete();
    last_val.delete();
    mem_auto = 1'b1;
    for (int n = 0; n < 80; n++) begin
      int unsigned op;
      int waited;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic is_rd;
      op = $urandom_range(0, 9);
      a  = 28'h200 + AW'($urandom_range(0, 7));
      d  = {$urandom, $urandom, $urandom, $urandom};
      is_rd = (op < 4) || (op == 9);
      l2_mem_read = is_rd; l2_mem_write = (op >= 4);
      l2_mem_addr = a; l2_mem_wdata = d;
      waited = 0;
      do begin
        tick();
        waited++;
      end while (!l2_mem_ready && waited < 300);
      check($sformatf("rand%0d completes", n), l2_mem_ready, 1);
      if (l2_mem_ready) begin
        if (is_rd) check($sformatf("rand%0d rdata", n), l2_mem_rdata, model_get(a));
        else       last_val[a] = d;
      end
      check($sformatf("rand%0d count bound", n), wb_count <= 3'd4, 1);
      $display("txn %0d %s addr=%0h cycles=%0d count=%0d", n, is_rd ? "rd" : "wr", a, waited, wb_count);
      clear_req();
      repeat ($urandom_range(0, 2)) tick();
    end
    begin
      int waited;
      waited = 0;
      while (!(wb_empty && !mem_write && !mem_read && !mem_ready) && waited < 500) begin
        tick();
        waited++;
      end
      check("rand drained", wb_empty && !mem_write, 1);
    end
    for (int i = 0; i < 8; i++) begin
      logic [AW-1:0] a;
      a = 28'h200 + AW'(i);
      check($sformatf("final mem %0h", a), mem_get(a), model_get(a));
    end
    mem_auto = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
